// File: rtl/lcd_i2c_pkg.sv
// rtl/lcd_i2c_pkg.sv - shared states, register offsets and bit positions for the LCD I2C target
package lcd_i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } i2c_state_t;

    // Avalon word offsets: words 0-7 map straight onto bank[0..7]
    localparam logic [3:0] REG_BANK_FIRST = 4'd0;
    localparam logic [3:0] REG_BANK_LAST  = 4'd7;
    localparam logic [3:0] REG_CTRL       = 4'd8;
    localparam logic [3:0] REG_STATUS     = 4'd9;

    // CTRL word layout
    localparam int CTRL_ENABLE_BIT  = 7;
    localparam int CTRL_ADDR_MSB    = 6;

    // STATUS word layout
    localparam int STATUS_ADDRESSED_BIT = 0;
    localparam int STATUS_BUSY_BIT      = 1;
    localparam int STATUS_OVERFLOW_BIT  = 2;

endpackage

// File: rtl/lcd_i2c_target_if.sv
// rtl/lcd_i2c_target_if.sv - Avalon-MM register port of the LCD I2C target
interface lcd_i2c_target_if;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/lcd_i2c_line_cond.sv
// rtl/lcd_i2c_line_cond.sv - SCL/SDA synchronizer, optional LCD_I2C_TGT_GLITCH_FILTER_EN majority filter, edge and START/STOP detect
module lcd_i2c_line_cond #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_c;
    logic                   sda_c;
    logic                   scl_q;
    logic                   sda_q;

    // Multi-stage synchronizers; idle bus level is high, so reset to 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
        end
    end

`ifdef LCD_I2C_TGT_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Majority of the current and two previous samples rejects single-clk spikes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl_c    <= 1'b1;
            sda_c    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[SYNC_STAGES-1]};
            sda_hist <= {sda_hist[0], sda_sync[SYNC_STAGES-1]};
            scl_c    <= maj3(scl_sync[SYNC_STAGES-1], scl_hist[0], scl_hist[1]);
            sda_c    <= maj3(sda_sync[SYNC_STAGES-1], sda_hist[0], sda_hist[1]);
        end
    end
`else
    assign scl_c = scl_sync[SYNC_STAGES-1];
    assign sda_c = sda_sync[SYNC_STAGES-1];
`endif

    // Previous conditioned levels for edge and START/STOP detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_c;
            sda_q <= sda_c;
        end
    end

    assign sda      = sda_c;
    assign scl_rise = scl_c & ~scl_q;
    assign scl_fall = ~scl_c & scl_q;
    assign start    = scl_c & scl_q & sda_q & ~sda_c;
    assign stop     = scl_c & scl_q & ~sda_q & sda_c;

endmodule

// File: rtl/lcd_i2c_target.sv
// rtl/lcd_i2c_target.sv - I2C target with 8-byte register bank shared with an Avalon-MM port
module lcd_i2c_target
    import lcd_i2c_pkg::*;
#(
    parameter logic [6:0] DEFAULT_ADDR = 7'h3C,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    lcd_i2c_target_if.slave   avs
);

    logic        sda;
    logic        scl_rise;
    logic        scl_fall;
    logic        start;
    logic        stop;

    logic [7:0]  bank [8];
    i2c_state_t  state;
    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [2:0]  ptr;
    logic [2:0]  ptr_inc;
    logic        rw;
    logic        mack;
    logic        busy;
    logic        addressed;
    logic        overflow;
    logic        enable;
    logic [6:0]  own_addr;

    logic        av_wr;
    logic        av_rd;
    logic        i2c_commit;
    logic        collision;
    logic [31:0] rd_word;
    logic        unused_writedata;

    lcd_i2c_line_cond #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_cond (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign av_wr      = avs.chipselect & ~avs.write_n;
    assign av_rd      = avs.chipselect & avs.write_n;
    assign ptr_inc    = ptr + 3'd1;
    assign i2c_commit = scl_fall && (state == WDATA) && (bit_cnt == 4'd8);
    assign collision  = i2c_commit && av_wr && !avs.address[3] && (avs.address[2:0] == ptr);
    assign unused_writedata = ^avs.writedata[31:8];

    // Avalon read mux; unmapped words and unused bits read 0
    always_comb begin
        rd_word = '0;
        if (avs.address <= REG_BANK_LAST) begin
            rd_word[7:0] = bank[avs.address[2:0]];
        end else if (avs.address == REG_CTRL) begin
            rd_word[CTRL_ENABLE_BIT]    = enable;
            rd_word[CTRL_ADDR_MSB:0]    = own_addr;
        end else if (avs.address == REG_STATUS) begin
            rd_word[STATUS_OVERFLOW_BIT]  = overflow;
            rd_word[STATUS_BUSY_BIT]      = busy;
            rd_word[STATUS_ADDRESSED_BIT] = addressed;
        end
    end

    // Registered read data, updated only on Avalon read cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs.readdata <= '0;
        end else if (av_rd) begin
            avs.readdata <= rd_word;
        end
    end

    // Register bank and CTRL/overflow; the Avalon write is applied last so it wins a collision
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                bank[i] <= '0;
            end
            own_addr <= DEFAULT_ADDR;
            enable   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (i2c_commit) begin
                bank[ptr] <= shreg;
            end
            if (av_wr && (avs.address <= REG_BANK_LAST)) begin
                bank[avs.address[2:0]] <= avs.writedata[7:0];
            end
            if (av_wr && (avs.address == REG_CTRL)) begin
                enable   <= avs.writedata[CTRL_ENABLE_BIT];
                own_addr <= avs.writedata[CTRL_ADDR_MSB:0];
            end
            if (collision) begin
                overflow <= 1'b1;
            end else if (av_wr && (avs.address == REG_STATUS) && avs.writedata[STATUS_OVERFLOW_BIT]) begin
                overflow <= 1'b0;
            end
        end
    end

    // I2C protocol FSM: sample on SCL rise, drive sda_oe on SCL fall; STOP/START override everything
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            mack      <= 1'b1;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            addressed <= 1'b0;
        end else if (stop) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            addressed <= 1'b0;
        end else if (start) begin
            state   <= ADDR;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b1;
        end else begin
            if (scl_rise) begin
                if ((state inside {ADDR, PTR, WDATA}) && (bit_cnt != 4'd8)) begin
                    shreg   <= {shreg[6:0], sda};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if (state == RDATA_ACK) begin
                    mack <= sda;
                end
            end
            if (scl_fall) begin
                case (state)
                    ADDR: begin
                        if (bit_cnt == 4'd8) begin
                            rw <= shreg[0];
                            if (enable && (shreg[7:1] == own_addr)) begin
                                state     <= ADDR_ACK;
                                sda_oe    <= 1'b1;
                                addressed <= 1'b1;
                            end else begin
                                state  <= IDLE;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (rw) begin
                            state   <= RDATA;
                            shreg   <= {bank[ptr][6:0], 1'b0};
                            sda_oe  <= ~bank[ptr][7];
                            bit_cnt <= 4'd1;
                        end else begin
                            state   <= PTR;
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                        end
                    end
                    PTR: begin
                        if (bit_cnt == 4'd8) begin
                            ptr    <= shreg[2:0];
                            sda_oe <= 1'b1;
                            state  <= PTR_ACK;
                        end
                    end
                    WDATA: begin
                        if (bit_cnt == 4'd8) begin
                            ptr    <= ptr_inc;
                            sda_oe <= 1'b1;
                            state  <= WDATA_ACK;
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= '0;
                        state   <= WDATA;
                    end
                    RDATA: begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            state  <= RDATA_ACK;
                        end else begin
                            sda_oe  <= ~shreg[7];
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    RDATA_ACK: begin
                        if (!mack) begin
                            ptr     <= ptr_inc;
                            shreg   <= {bank[ptr_inc][6:0], 1'b0};
                            sda_oe  <= ~bank[ptr_inc][7];
                            bit_cnt <= 4'd1;
                            state   <= RDATA;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_i2c_target.sv
// tb/tb_lcd_i2c_target.sv - directed self-checking bench for lcd_i2c_target
module tb_lcd_i2c_target;

    localparam int Q = 8;
`ifdef LCD_I2C_TGT_GLITCH_FILTER_EN
    localparam int FLT = 2;
`else
    localparam int FLT = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic sda_oe;
    logic sda_line;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   oe_cnt = 0;

    lcd_i2c_target_if bus ();

    assign sda_line = sda_m & ~sda_oe;

    lcd_i2c_target dut (
        .clk     (clk),
        .reset_n (reset_n),
        .scl_in  (scl_m),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .avs     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic av_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic av_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a;
        @(negedge clk);
        bus.chipselect = 1'b0;
        d = bus.readdata;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    // Shift out the top n bits; with collide, an Avalon write of 0x55 to word 4
    // is lined up with the clk in which the target commits the received byte
    task automatic write_bits(input logic [7:0] b, input int n, input bit collide);
        for (int i = 0; i < n; i++) begin
            sda_m = b[7-i]; wq();
            scl_m = 1'b1; wq();
            scl_m = 1'b0;
            if (collide && i == 7) begin
                repeat (2 + FLT) @(posedge clk);
                #1;
                bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 4'd4; bus.writedata = 32'h55;
                @(posedge clk);
                #1;
                bus.chipselect = 1'b0; bus.write_n = 1'b1;
            end
            wq();
        end
    endtask

    task automatic get_ack(output logic ack);
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        ack = sda_line;
        scl_m = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        write_bits(b, 8, 1'b0);
        get_ack(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        sda_m = 1'b1;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            wq();
            scl_m = 1'b1; wq();
            b = {b[6:0], sda_line};
            scl_m = 1'b0;
        end
        wq();
        sda_m = nack; wq();
        scl_m = 1'b1; wq();
        scl_m = 1'b0; wq();
        sda_m = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        ack;
        logic [7:0]  rb;
        logic [7:0]  t1_bytes [4];
        int          oe_before;

        t1_bytes[0] = 8'h78; t1_bytes[1] = 8'h02; t1_bytes[2] = 8'hAA; t1_bytes[3] = 8'hBB;
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = '0; bus.writedata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 32'h0);
        check("rst_readdata", bus.readdata, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        av_read(4'd8, rd);  check("rst_ctrl", rd, 32'h3C);
        av_read(4'd9, rd);  check("rst_status", rd, 32'h0);
        av_read(4'd0, rd);  check("rst_bank0", rd, 32'h0);

        // I2C write of pointer 2 then 0xAA, 0xBB
        av_write(4'd8, 32'hBC);
        av_read(4'd8, rd);  check("ctrl_rw", rd, 32'hBC);
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(t1_bytes[i], ack);
            check($sformatf("t1_ack%0d", i), 32'(ack), 32'h0);
        end
        av_read(4'd9, rd);  check("t1_status_mid", rd, 32'h3);
        i2c_stop();
        av_read(4'd9, rd);  check("t1_status_end", rd, 32'h0);
        av_read(4'd2, rd);  check("t1_word2", rd, 32'hAA);
        av_read(4'd3, rd);  check("t1_word3", rd, 32'hBB);

        // Read with repeated START, pointer wrap 7 -> 0
        av_write(4'd7, 32'h11);
        av_write(4'd0, 32'h22);
        i2c_start();
        write_byte(8'h78, ack); check("t2_ack_addr", 32'(ack), 32'h0);
        write_byte(8'h07, ack); check("t2_ack_ptr", 32'(ack), 32'h0);
        i2c_rstart();
        write_byte(8'h79, ack); check("t2_ack_raddr", 32'(ack), 32'h0);
        read_byte(1'b0, rb);    check("t2_rd0", 32'(rb), 32'h11);
        read_byte(1'b1, rb);    check("t2_rd1", 32'(rb), 32'h22);
        i2c_stop();
        av_read(4'd9, rd);  check("t2_status", rd, 32'h0);

        // Avalon width/unmapped behaviour
        av_write(4'd1, 32'hFFFFFF5A);
        av_read(4'd1, rd);  check("bank_upper_zero", rd, 32'h5A);
        av_write(4'd12, 32'hFFFFFFFF);
        av_read(4'd12, rd); check("unmapped_zero", rd, 32'h0);

        // Disabled target, then wrong address: never ACKs, bank untouched
        oe_before = oe_cnt;
        av_write(4'd8, 32'h3C);
        i2c_start();
        write_byte(8'h78, ack); check("t3_dis_nack", 32'(ack), 32'h1);
        write_byte(8'h00, ack);
        write_byte(8'h99, ack);
        i2c_stop();
        av_write(4'd8, 32'hBC);
        i2c_start();
        write_byte(8'hA0, ack); check("t3_addr_nack", 32'(ack), 32'h1);
        write_byte(8'h00, ack);
        write_byte(8'h99, ack);
        i2c_stop();
        check("t3_no_pull", 32'(oe_cnt - oe_before), 32'h0);
        av_read(4'd0, rd);  check("t3_bank0", rd, 32'h22);

        // STOP in the middle of a data byte
        i2c_start();
        write_byte(8'h78, ack); check("t4_ack_addr", 32'(ack), 32'h0);
        write_byte(8'h01, ack); check("t4_ack_ptr", 32'(ack), 32'h0);
        write_bits(8'hC3, 4, 1'b0);
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1;
        repeat (3 + FLT) @(negedge clk);
        check("t4_sda_oe", 32'(sda_oe), 32'h0);
        av_read(4'd9, rd);  check("t4_status", rd, 32'h0);
        av_read(4'd1, rd);  check("t4_bank1", rd, 32'h5A);
        wq();

        // Same-clk Avalon and I2C write to bank[4]
        i2c_start();
        write_byte(8'h78, ack); check("t5_ack_addr", 32'(ack), 32'h0);
        write_byte(8'h04, ack); check("t5_ack_ptr", 32'(ack), 32'h0);
        write_bits(8'h66, 8, 1'b1);
        get_ack(ack);           check("t5_ack_data", 32'(ack), 32'h0);
        i2c_stop();
        av_read(4'd4, rd);  check("t5_bank4", rd, 32'h55);
        av_read(4'd9, rd);  check("t5_status_ovf", rd, 32'h4);
        av_write(4'd9, 32'h4);
        av_read(4'd9, rd);  check("t5_status_clr", rd, 32'h0);

        // Reset in the middle of a read while the target drives SDA
        i2c_start();
        write_byte(8'h78, ack); check("t6_ack_addr", 32'(ack), 32'h0);
        write_byte(8'h05, ack); check("t6_ack_ptr", 32'(ack), 32'h0);
        i2c_rstart();
        write_byte(8'h79, ack); check("t6_ack_raddr", 32'(ack), 32'h0);
        check("t6_driving", 32'(sda_oe), 32'h1);
        av_read(4'd7, rd);  check("t6_pre_word7", rd, 32'h11);
        reset_n = 1'b0;
        #1;
        check("t6_rst_sda_oe", 32'(sda_oe), 32'h0);
        check("t6_rst_readdata", bus.readdata, 32'h0);
        scl_m = 1'b1; sda_m = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        av_read(4'd8, rd);  check("t6_ctrl", rd, 32'h3C);
        av_read(4'd9, rd);  check("t6_status", rd, 32'h0);
        av_read(4'd7, rd);  check("t6_bank7", rd, 32'h0);
        av_read(4'd4, rd);  check("t6_bank4", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
